depatchifier: RTL and testbench

//  Inverse of the patch vectorizer. Captures one flat 1D patch vector of size*size pixels
//  (row-major, index = row*size + col) and rebuilds the 2D size x size patch one row per cycle.

---
 rtl/patch_pkg.sv | 16 +
 rtl/depatch_row_select.sv | 14 +
 rtl/depatchifier.sv | 91 +++++++++
 tb/tb_depatchifier.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patch_pkg.sv
// Shared pixel and FSM-state types for the patch vectorizer / depatchifier pair.
package patch_pkg;

    localparam int CHANNEL_SIZE = 8;
    localparam int NUM_CHANNELS = 3;
    localparam int PIXEL_WIDTH  = CHANNEL_SIZE * NUM_CHANNELS;

    typedef logic [PIXEL_WIDTH-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PROCESSING = 2'b10,
        DONE       = 2'b11
    } patch_state_t;

endpackage

// File: rtl/depatch_row_select.sv
// Combinational row slicer: returns the size pixels of one patch row from the flat vector.
module depatch_row_select
    import patch_pkg::*;
#(
    parameter int size = 16
) (
    input  pixel_t [size*size-1:0]   vec_buf,
    input  logic   [$clog2(size)-1:0] row,
    output pixel_t [size-1:0]        row_slice
);

    assign row_slice = vec_buf[int'(row)*size +: size];

endmodule

// File: rtl/depatchifier.sv
// Rebuilds a size x size patch from a flat row-major vector, one row per cycle.
// Optional feature: define DEPATCHIFIER_CHECKSUM_EN to add an XOR checksum output.
module depatchifier
    import patch_pkg::*;
#(
    parameter  int size              = 16,
    localparam int PATCH_VECTOR_SIZE = size * size,
    localparam int ROW_W             = $clog2(size)
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      en,
    input  logic                                      output_taken,
    input  logic [PATCH_VECTOR_SIZE-1:0][PIXEL_WIDTH-1:0] vectorized_patch,
    output logic [1:0]                                state,
`ifdef DEPATCHIFIER_CHECKSUM_EN
    output logic [PIXEL_WIDTH-1:0]                    checksum,
`endif
    output logic [size-1:0][size-1:0][PIXEL_WIDTH-1:0] patch_out
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(size - 1);

    patch_state_t                     state_q;
    logic   [ROW_W-1:0]               row;
    pixel_t [PATCH_VECTOR_SIZE-1:0]   vec_buf;
    pixel_t [size-1:0][size-1:0]      pat_buf;
    pixel_t [size-1:0]                row_slice;

    depatch_row_select #(.size(size)) u_row_select (
        .vec_buf   (vec_buf),
        .row       (row),
        .row_slice (row_slice)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            row     <= '0;
            vec_buf <= '0;
            pat_buf <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        vec_buf <= vectorized_patch;
                        row     <= '0;
                        state_q <= PROCESSING;
                    end
                end
                PROCESSING: begin
                    pat_buf[row] <= row_slice;
                    // Counter parks on the last row rather than wrapping.
                    if (row == LAST_ROW) state_q <= DONE;
                    else                 row     <= row + 1'b1;
                end
                DONE: begin
                    if (output_taken) begin
                        pat_buf <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign state     = state_q;
    assign patch_out = (state_q == DONE) ? pat_buf : '0;

`ifdef DEPATCHIFIER_CHECKSUM_EN
    pixel_t row_xor;
    pixel_t csum_acc;

    always_comb begin
        row_xor = '0;
        for (int c = 0; c < size; c++) row_xor = row_xor ^ row_slice[c];
    end

    // Folds in the same row slice that is being copied, so it completes with the patch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                               csum_acc <= '0;
        else if (state_q == PROCESSING)             csum_acc <= csum_acc ^ row_xor;
        else if (state_q == DONE && output_taken)   csum_acc <= '0;
        else if (state_q == IDLE && en)             csum_acc <= '0;
    end

    assign checksum = (state_q == DONE) ? csum_acc : '0;
`endif

endmodule

// File: tb/tb_depatchifier.sv
// Self-checking bench for depatchifier against a flat-vector reference model.
module tb_depatchifier;
    import patch_pkg::*;

    localparam int SZ = 16;
    localparam int N  = SZ * SZ;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic output_taken = 1'b0;
    logic [N-1:0][PIXEL_WIDTH-1:0] vectorized_patch = '0;
    logic [1:0] state;
    logic [SZ-1:0][SZ-1:0][PIXEL_WIDTH-1:0] patch_out;
`ifdef DEPATCHIFIER_CHECKSUM_EN
    logic [PIXEL_WIDTH-1:0] checksum;
`endif

    int vectors = 0;
    int miscompares = 0;
    pixel_t model [N];

    depatchifier #(.size(SZ)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .en               (en),
        .output_taken     (output_taken),
        .vectorized_patch (vectorized_patch),
        .state            (state),
`ifdef DEPATCHIFIER_CHECKSUM_EN
        .checksum         (checksum),
`endif
        .patch_out        (patch_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_patch;
        for (int k = 0; k < N; k++) vectorized_patch[k] = model[k];
        en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (state !== 2'b11 && cycles < 40) begin
            tick();
            cycles++;
        end
        if (state !== 2'b11) cycles = -1;
    endtask

    task automatic release_patch;
        output_taken = 1'b1;
        tick();
        output_taken = 1'b0;
    endtask

    // Pixels of patch_out that disagree with model[r*SZ+c].
    function automatic int count_bad();
        int bad = 0;
        for (int r = 0; r < SZ; r++)
            for (int c = 0; c < SZ; c++)
                if (patch_out[r][c] !== model[r*SZ + c]) bad++;
        return bad;
    endfunction

    function automatic pixel_t model_xor();
        pixel_t x = '0;
        for (int k = 0; k < N; k++) x ^= model[k];
        return x;
    endfunction

    function automatic logic out_is_zero();
        return patch_out === '0;
    endfunction

    task automatic test_reset;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: got %b expected 00", state);
        end
        vectors++;
        if (!out_is_zero()) begin
            miscompares++;
            $display("FAIL reset_patch_out: got nonzero expected 0");
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_ramp;
        int cyc;
        for (int k = 0; k < N; k++) model[k] = pixel_t'(k);
        start_patch();
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL ramp_enter_processing: got %b expected 10", state);
        end
        vectors++;
        if (!out_is_zero()) begin
            miscompares++;
            $display("FAIL ramp_gated_output: got nonzero expected 0");
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL ramp_latency: got %0d expected 16", cyc);
        end
        vectors++;
        if (count_bad() !== 0) begin
            miscompares++;
            $display("FAIL ramp_patch: %0d bad pixels expected 0", count_bad());
        end
        vectors++;
        if (patch_out[15][15] !== 24'd255) begin
            miscompares++;
            $display("FAIL ramp_15_15: got %0d expected 255", patch_out[15][15]);
        end
        vectors++;
        if (patch_out[3][7] !== 24'd55) begin
            miscompares++;
            $display("FAIL ramp_3_7: got %0d expected 55", patch_out[3][7]);
        end
`ifdef DEPATCHIFIER_CHECKSUM_EN
        vectors++;
        if (checksum !== 24'h000000) begin
            miscompares++;
            $display("FAIL ramp_checksum: got %h expected 000000", checksum);
        end
`endif
        release_patch();
    endtask

    task automatic test_hold_release;
        int cyc;
        int unstable = 0;
        for (int k = 0; k < N; k++) model[k] = pixel_t'($urandom);
        start_patch();
        wait_done(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL hold_latency: got %0d expected 16", cyc);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (state !== 2'b11 || count_bad() !== 0) begin
                miscompares++;
                unstable++;
                $display("FAIL hold_stable: cycle %0d state %b bad pixels %0d expected 11 and 0", i, state, count_bad());
            end
        end
`ifdef DEPATCHIFIER_CHECKSUM_EN
        vectors++;
        if (checksum !== model_xor()) begin
            miscompares++;
            $display("FAIL hold_checksum: got %h expected %h", checksum, model_xor());
        end
`endif
        release_patch();
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL release_state: got %b expected 00", state);
        end
        vectors++;
        if (!out_is_zero()) begin
            miscompares++;
            $display("FAIL release_patch_out: got nonzero expected 0");
        end
`ifdef DEPATCHIFIER_CHECKSUM_EN
        vectors++;
        if (checksum !== '0) begin
            miscompares++;
            $display("FAIL release_checksum: got %h expected 000000", checksum);
        end
`endif
        output_taken = 1'b1;
        tick();
        output_taken = 1'b0;
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL taken_in_idle: got %b expected 00", state);
        end
    endtask

    task automatic test_isolation;
        int cyc;
        for (int k = 0; k < N; k++) model[k] = pixel_t'(k);
        start_patch();
        tick();
        tick();
        tick();
        for (int k = 0; k < N; k++) vectorized_patch[k] = 24'hFFFFFF;
        en = 1'b1;
        output_taken = 1'b1;
        tick();
        en = 1'b0;
        output_taken = 1'b0;
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL isolation_state: got %b expected 10", state);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 12) begin
            miscompares++;
            $display("FAIL isolation_latency: got %0d expected 12", cyc);
        end
        vectors++;
        if (count_bad() !== 0) begin
            miscompares++;
            $display("FAIL isolation_patch: %0d bad pixels expected 0", count_bad());
        end
        release_patch();
    endtask

    task automatic test_async_reset;
        int cyc;
        for (int k = 0; k < N; k++) model[k] = pixel_t'(k);
        start_patch();
        for (int i = 0; i < 7; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset_state: got %b expected 00", state);
        end
        vectors++;
        if (!out_is_zero()) begin
            miscompares++;
            $display("FAIL async_reset_patch_out: got nonzero expected 0");
        end
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < N; k++) model[k] = 24'h0A0B0C;
        start_patch();
        wait_done(cyc);
        vectors++;
        if (cyc !== 16) begin
            miscompares++;
            $display("FAIL post_reset_latency: got %0d expected 16", cyc);
        end
        vectors++;
        if (count_bad() !== 0) begin
            miscompares++;
            $display("FAIL post_reset_patch: %0d bad pixels expected 0", count_bad());
        end
        release_patch();
    endtask

    task automatic test_simultaneous;
        int cyc;
        for (int k = 0; k < N; k++) model[k] = pixel_t'($urandom);
        start_patch();
        wait_done(cyc);
        en = 1'b1;
        output_taken = 1'b1;
        tick();
        output_taken = 1'b0;
        vectors++;
        if (state !== 2'b00) begin
            miscompares++;
            $display("FAIL simul_state: got %b expected 00", state);
        end
        vectors++;
        if (!out_is_zero()) begin
            miscompares++;
            $display("FAIL simul_patch_out: got nonzero expected 0");
        end
        tick();
        en = 1'b0;
        vectors++;
        if (state !== 2'b10) begin
            miscompares++;
            $display("FAIL simul_restart: got %b expected 10", state);
        end
        wait_done(cyc);
        vectors++;
        if (cyc !== 16 || count_bad() !== 0) begin
            miscompares++;
            $display("FAIL simul_patch: latency %0d bad pixels %0d expected 16 and 0", cyc, count_bad());
        end
        release_patch();
    endtask

    task automatic test_back_to_back;
        int cyc;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < N; k++) model[k] = pixel_t'($urandom);
            start_patch();
            wait_done(cyc);
            vectors++;
            if (cyc !== 16 || count_bad() !== 0) begin
                miscompares++;
                $display("FAIL b2b_patch%0d: latency %0d bad pixels %0d expected 16 and 0", p, cyc, count_bad());
            end
`ifdef DEPATCHIFIER_CHECKSUM_EN
            vectors++;
            if (checksum !== model_xor()) begin
                miscompares++;
                $display("FAIL b2b_checksum%0d: got %h expected %h", p, checksum, model_xor());
            end
`endif
            release_patch();
        end
    endtask

`ifdef DEPATCHIFIER_CHECKSUM_EN
    task automatic test_checksum_single;
        int cyc;
        int idx;
        idx = int'($urandom_range(N - 1));
        for (int k = 0; k < N; k++) model[k] = '0;
        model[idx] = 24'h123456;
        start_patch();
        vectors++;
        if (checksum !== '0) begin
            miscompares++;
            $display("FAIL checksum_gated: got %h expected 000000", checksum);
        end
        wait_done(cyc);
        vectors++;
        if (checksum !== 24'h123456) begin
            miscompares++;
            $display("FAIL checksum_single: got %h expected 123456", checksum);
        end
        release_patch();
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_hold_release();
        test_isolation();
        test_async_reset();
        test_simultaneous();
        test_back_to_back();
`ifdef DEPATCHIFIER_CHECKSUM_EN
        test_checksum_single();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
